// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable Moore sequence detector:
// state encoding, pattern-length limits and a history-length width helper.
package seq_detect_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL  = 2'b00;
  localparam state_t ST_ARMED = 2'b01;
  localparam state_t ST_MATCH = 2'b10;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  // Width needed to count history fill from 0 up to and including pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// Serial stream, configuration and status bundle of the sequence detector.
// detect_sticky exists only when SEQ_DETECT_STICKY_EN is defined.
interface seq_detect_moore_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             inbits;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             overlap_en;
  logic             clear_cnt;
  logic             detect;
  logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_DETECT_STICKY_EN
  logic             detect_sticky;

  modport master (
    output in_valid, inbits, cfg_load, cfg_pattern, overlap_en, clear_cnt,
    input  detect, match_cnt, detect_sticky
  );
  modport slave (
    input  in_valid, inbits, cfg_load, cfg_pattern, overlap_en, clear_cnt,
    output detect, match_cnt, detect_sticky
  );
`else
  modport master (
    output in_valid, inbits, cfg_load, cfg_pattern, overlap_en, clear_cnt,
    input  detect, match_cnt
  );
  modport slave (
    input  in_valid, inbits, cfg_load, cfg_pattern, overlap_en, clear_cnt,
    output detect, match_cnt
  );
`endif
endinterface

// File: rtl/seq_detect_sat_cnt.sv
// Saturating up-counter with synchronous clear that wins over increment.
module seq_detect_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Runtime-programmable Moore serial sequence detector with match counter.
// Optional detect_sticky output enabled by SEQ_DETECT_STICKY_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_FILL  | history not yet holding PAT_W bits
//   ST_ARMED | history full, last valid bit did not match
//   ST_MATCH | pattern just matched, detect high for one cycle
module seq_detect_moore_param
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1011),
  parameter int             CNT_W       = 8
) (
  input logic                     clk,
  input logic                     reset,
  seq_detect_moore_param_if.slave bus
);

  localparam int               LEN_W    = len_w(PAT_W);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(PAT_W);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detect_moore_param: PAT_W out of range");
  end

  state_t           state, state_next;
  logic [PAT_W-1:0] hist, hist_next, pattern_q;
  logic [LEN_W-1:0] hist_len, hist_len_shift, hist_len_next;
  logic             match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_FILL;
      hist      <= '0;
      hist_len  <= '0;
      pattern_q <= PAT_DEFAULT;
    end else begin
      state    <= state_next;
      hist     <= hist_next;
      hist_len <= hist_len_next;
      if (bus.cfg_load) pattern_q <= bus.cfg_pattern;
    end
  end

  always_comb begin
    hist_next      = hist;
    hist_len_shift = hist_len;
    if (bus.in_valid) begin
      hist_next = {hist[PAT_W-2:0], bus.inbits};
      if (hist_len != LEN_FULL) hist_len_shift = hist_len + LEN_W'(1);
    end
    match = bus.in_valid && (hist_len_shift == LEN_FULL) && (hist_next == pattern_q);
    // Non-overlap mode forgets the matched bits at the edge that enters MATCH.
    hist_len_next = (match && !bus.overlap_en) ? '0 : hist_len_shift;
    state_next    = ST_FILL;

    if (bus.cfg_load) begin
      hist_next     = hist;
      hist_len_next = '0;
      match         = 1'b0;
      state_next    = ST_FILL;
    end else begin
      case (state)
        ST_FILL, ST_ARMED, ST_MATCH: begin
          if (match)                           state_next = ST_MATCH;
          else if (hist_len_shift == LEN_FULL) state_next = ST_ARMED;
          else                                 state_next = ST_FILL;
        end
        default: begin
          hist_len_next = '0;
          match         = 1'b0;
          state_next    = ST_FILL;
        end
      endcase
    end
  end

  always_comb begin
    bus.detect = (state == ST_MATCH);
  end

  seq_detect_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_cnt),
    .inc   (match),
    .cnt   (bus.match_cnt)
  );

`ifdef SEQ_DETECT_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!reset)             sticky_q <= 1'b0;
    else if (bus.clear_cnt) sticky_q <= 1'b0;
    else if (match)         sticky_q <= 1'b1;
  end

  assign bus.detect_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed self-checking bench for seq_detect_moore_param (default and
// CNT_W=2 instances share one stimulus; sticky checks with SEQ_DETECT_STICKY_EN).
module tb_seq_detect_moore_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, inbits, cfg_load, overlap_en, clear_cnt;
  logic [3:0] cfg_pattern;
  int         checks = 0;
  int         errors = 0;

  seq_detect_moore_param_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
  seq_detect_moore_param_if #(.PAT_W(4), .CNT_W(2)) bus_b ();

  assign bus_a.in_valid    = in_valid;
  assign bus_a.inbits      = inbits;
  assign bus_a.cfg_load    = cfg_load;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.overlap_en  = overlap_en;
  assign bus_a.clear_cnt   = clear_cnt;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.inbits      = inbits;
  assign bus_b.cfg_load    = cfg_load;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.overlap_en  = overlap_en;
  assign bus_b.clear_cnt   = clear_cnt;

  seq_detect_moore_param #(.PAT_W(4), .PAT_DEFAULT(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  seq_detect_moore_param #(.PAT_W(4), .PAT_DEFAULT(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given serial input; one-shot controls drop afterwards.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    inbits   = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_load  = 1'b0;
    clear_cnt = 1'b0;
    reset     = 1'b1;
  endtask

  // Bits and expected detect given MSB-first over n valid cycles.
  task automatic stream(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] det);
    logic [15:0] b, d;
    b = bits;
    d = det;
    for (int i = 0; i < n; i++) begin
      step(1'b1, b[n-1-i]);
      chk($sformatf("%s_det[%0d]", tag, i+1), {31'd0, bus_a.detect}, {31'd0, d[n-1-i]});
    end
  endtask

  task automatic load(input logic [3:0] pat);
    cfg_pattern = pat;
    cfg_load    = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; inbits = 1'b1; cfg_load = 1'b0;
    clear_cnt = 1'b0; overlap_en = 1'b1; cfg_pattern = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det", {31'd0, bus_a.detect}, 32'd0);
    chk("rst_cnt_a", {24'd0, bus_a.match_cnt}, 32'd0);
    chk("rst_cnt_b", {30'd0, bus_b.match_cnt}, 32'd0);
`ifdef SEQ_DETECT_STICKY_EN
    chk("rst_sticky", {31'd0, bus_a.detect_sticky}, 32'd0);
`endif
    reset = 1'b1; in_valid = 1'b0;

    // Default pattern 1011, overlapping
    overlap_en = 1'b1;
    stream("ovl", 7, 16'b1011011, 16'b0001001);
    chk("ovl_cnt", {24'd0, bus_a.match_cnt}, 32'd2);
`ifdef SEQ_DETECT_STICKY_EN
    chk("ovl_sticky", {31'd0, bus_a.detect_sticky}, 32'd1);
`endif
    load(4'b1011);
    chk("load_keeps_cnt", {24'd0, bus_a.match_cnt}, 32'd2);
    chk("load_det", {31'd0, bus_a.detect}, 32'd0);
    clear_cnt = 1'b1;
    step(1'b0, 1'b0);
    chk("clr_cnt", {24'd0, bus_a.match_cnt}, 32'd0);

    overlap_en = 1'b0;
    stream("novl", 7, 16'b1011011, 16'b0001000);
    chk("novl_cnt", {24'd0, bus_a.match_cnt}, 32'd1);

    load(4'b1111);
    stream("ones_novl", 7, 16'b1111111, 16'b0001000);
    chk("ones_novl_cnt", {24'd0, bus_a.match_cnt}, 32'd2);
    overlap_en = 1'b1;
    load(4'b1111);
    stream("ones_ovl", 7, 16'b1111111, 16'b0001111);
    chk("ones_ovl_cnt_a", {24'd0, bus_a.match_cnt}, 32'd6);
    chk("ones_ovl_cnt_b", {30'd0, bus_b.match_cnt}, 32'd3);

    // Saturation on the CNT_W=2 instance
    cfg_pattern = 4'b1111; cfg_load = 1'b1; clear_cnt = 1'b1;
    step(1'b0, 1'b0);
    chk("sat_clr_b", {30'd0, bus_b.match_cnt}, 32'd0);
`ifdef SEQ_DETECT_STICKY_EN
    chk("sat_clr_sticky", {31'd0, bus_a.detect_sticky}, 32'd0);
`endif
    stream("sat", 6, 16'b111111, 16'b000111);
    chk("sat_mid_b", {30'd0, bus_b.match_cnt}, 32'd3);
    stream("sat2", 2, 16'b11, 16'b11);
    chk("sat_end_b", {30'd0, bus_b.match_cnt}, 32'd3);
    chk("sat_end_a", {24'd0, bus_a.match_cnt}, 32'd5);

    // Gapped stream: single one-cycle pulse
    overlap_en = 1'b0;
    load(4'b1011);
    begin
      logic [3:0] gb;
      gb = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, gb[3-i]);
        chk($sformatf("gap_det[%0d]", i+1), {31'd0, bus_a.detect}, (i == 3) ? 32'd1 : 32'd0);
        for (int j = 0; j < 3; j++) begin
          step(1'b0, 1'b0);
          chk($sformatf("gap_idle[%0d.%0d]", i+1, j+1), {31'd0, bus_a.detect}, 32'd0);
        end
      end
    end
    chk("gap_cnt", {24'd0, bus_a.match_cnt}, 32'd6);

    // Load flushes history; a valid bit in the load cycle is dropped
    stream("pre_load", 2, 16'b10, 16'b00);
    load(4'b0110);
    stream("after_load", 4, 16'b0110, 16'b0001);
    cfg_pattern = 4'b0110; cfg_load = 1'b1;
    step(1'b1, 1'b0);
    stream("discard", 3, 16'b110, 16'b000);
    chk("discard_cnt", {24'd0, bus_a.match_cnt}, 32'd7);

    // Clear coincident with a match: clear wins
    overlap_en = 1'b1;
    load(4'b1111);
    stream("pre_clr", 3, 16'b111, 16'b000);
    clear_cnt = 1'b1;
    step(1'b1, 1'b1);
    chk("clr_hit_det", {31'd0, bus_a.detect}, 32'd1);
    chk("clr_hit_cnt_a", {24'd0, bus_a.match_cnt}, 32'd0);
    chk("clr_hit_cnt_b", {30'd0, bus_b.match_cnt}, 32'd0);
`ifdef SEQ_DETECT_STICKY_EN
    chk("clr_hit_sticky", {31'd0, bus_a.detect_sticky}, 32'd0);
`endif
    step(1'b1, 1'b1);
    chk("post_clr_det", {31'd0, bus_a.detect}, 32'd1);
    chk("post_clr_cnt", {24'd0, bus_a.match_cnt}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (i == 0) chk("idle_det", {31'd0, bus_a.detect}, 32'd0);
`ifdef SEQ_DETECT_STICKY_EN
      chk($sformatf("sticky_hold[%0d]", i+1), {31'd0, bus_a.detect_sticky}, 32'd1);
`endif
    end
    clear_cnt = 1'b1;
    step(1'b0, 1'b0);
    chk("final_clr_cnt", {24'd0, bus_a.match_cnt}, 32'd0);
`ifdef SEQ_DETECT_STICKY_EN
    chk("sticky_clr", {31'd0, bus_a.detect_sticky}, 32'd0);
`endif

    // Reset while in MATCH drops detect at that edge
    step(1'b1, 1'b1);
    chk("pre_rst_det", {31'd0, bus_a.detect}, 32'd1);
    reset = 1'b0;
    step(1'b1, 1'b1);
    chk("mid_rst_det", {31'd0, bus_a.detect}, 32'd0);
    chk("mid_rst_cnt", {24'd0, bus_a.match_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
